// File: rtl/hash_flag_pkg.sv
// Shared types for the hash-table valid-flag slot allocator.
package hash_flag_pkg;

  typedef enum logic {
    OP_INSERT = 1'b0,
    OP_DELETE = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CHECK = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [1:0] SEL_0 = 2'd0;
  localparam logic [1:0] SEL_1 = 2'd1;
  localparam logic [1:0] SEL_2 = 2'd2;

endpackage

// File: rtl/flag_slot_allocator_first_zero_finder.sv
// Finds the lowest-index zero bit of a bucket flag word.
module first_zero_finder #(
  parameter int unsigned BUCKET_SIZE = 1,
  localparam int unsigned SLOT_W = (BUCKET_SIZE > 1) ? $clog2(BUCKET_SIZE) : 1
) (
  input  logic [BUCKET_SIZE-1:0] word,
  output logic                   found_c,
  output logic [SLOT_W-1:0]      idx_c
);

  // Scan high to low so the lowest zero bit is the last one assigned.
  always_comb begin
    found_c = 1'b0;
    idx_c   = '0;
    for (int i = int'(BUCKET_SIZE) - 1; i >= 0; i--) begin
      if (!word[i]) begin
        found_c = 1'b1;
        idx_c   = SLOT_W'(i);
      end
    end
  end

endmodule

// File: rtl/flag_slot_allocator.sv
// Insert/delete controller sitting in front of the hash-table valid-flag register:
// reads three buckets, claims or clears one slot, writes the flag word back.
module flag_slot_allocator
  import hash_flag_pkg::*;
#(
  parameter int unsigned SIZE        = 10,
  parameter int unsigned BUCKET_SIZE = 1,
  localparam int unsigned SLOT_W = (BUCKET_SIZE > 1) ? $clog2(BUCKET_SIZE) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_op,
  input  logic [SIZE-1:0]        req_adr_0,
  input  logic [SIZE-1:0]        req_adr_1,
  input  logic [SIZE-1:0]        req_adr_2,
  input  logic [SLOT_W-1:0]      req_slot,
  output logic [SIZE-1:0]        flag_read_adr_0,
  output logic [SIZE-1:0]        flag_read_adr_1,
  output logic [SIZE-1:0]        flag_read_adr_2,
  input  logic [BUCKET_SIZE-1:0] flag_in_0,
  input  logic [BUCKET_SIZE-1:0] flag_in_1,
  input  logic [BUCKET_SIZE-1:0] flag_in_2,
  output logic [SIZE-1:0]        flag_write_adr,
  output logic                   flag_write_en,
  output logic [BUCKET_SIZE-1:0] flag_write_is_valid,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [1:0]             rsp_sel,
  output logic [SIZE-1:0]        rsp_adr,
  output logic [SLOT_W-1:0]      rsp_slot,
  output logic                   rsp_full,
  output logic                   rsp_was_set
);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [SIZE-1:0]    adr0_q, adr0_d, adr1_q, adr1_d, adr2_q, adr2_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic [1:0]         rsp_sel_q, rsp_sel_d;
  logic [SIZE-1:0]    rsp_adr_q, rsp_adr_d;
  logic [SLOT_W-1:0]  rsp_slot_q, rsp_slot_d;
  logic               rsp_full_q, rsp_full_d;
  logic               rsp_was_set_q, rsp_was_set_d;

  logic                   wr_en;
  logic [SIZE-1:0]        wr_adr;
  logic [BUCKET_SIZE-1:0] wr_word;
  logic [BUCKET_SIZE-1:0] del_shift;

  logic              found_0, found_1, found_2;
  logic [SLOT_W-1:0] idx_0, idx_1, idx_2;

  first_zero_finder #(.BUCKET_SIZE(BUCKET_SIZE)) u_fzf_0 (.word(flag_in_0), .found_c(found_0), .idx_c(idx_0));
  first_zero_finder #(.BUCKET_SIZE(BUCKET_SIZE)) u_fzf_1 (.word(flag_in_1), .found_c(found_1), .idx_c(idx_1));
  first_zero_finder #(.BUCKET_SIZE(BUCKET_SIZE)) u_fzf_2 (.word(flag_in_2), .found_c(found_2), .idx_c(idx_2));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      op_q          <= OP_INSERT;
      adr0_q        <= '0;
      adr1_q        <= '0;
      adr2_q        <= '0;
      slot_q        <= '0;
      rsp_sel_q     <= '0;
      rsp_adr_q     <= '0;
      rsp_slot_q    <= '0;
      rsp_full_q    <= 1'b0;
      rsp_was_set_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      adr0_q        <= adr0_d;
      adr1_q        <= adr1_d;
      adr2_q        <= adr2_d;
      slot_q        <= slot_d;
      rsp_sel_q     <= rsp_sel_d;
      rsp_adr_q     <= rsp_adr_d;
      rsp_slot_q    <= rsp_slot_d;
      rsp_full_q    <= rsp_full_d;
      rsp_was_set_q <= rsp_was_set_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    adr0_d        = adr0_q;
    adr1_d        = adr1_q;
    adr2_d        = adr2_q;
    slot_d        = slot_q;
    rsp_sel_d     = rsp_sel_q;
    rsp_adr_d     = rsp_adr_q;
    rsp_slot_d    = rsp_slot_q;
    rsp_full_d    = rsp_full_q;
    rsp_was_set_d = rsp_was_set_q;
    wr_en         = 1'b0;
    wr_adr        = '0;
    wr_word       = '0;
    del_shift     = flag_in_0 >> slot_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d   = op_e'(req_op);
          adr0_d = req_adr_0;
          // DELETE only touches adr_0, so all three read ports point there.
          adr1_d = req_op ? req_adr_0 : req_adr_1;
          adr2_d = req_op ? req_adr_0 : req_adr_2;
          slot_d = req_slot;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = CHECK;
      CHECK: begin
        rsp_sel_d     = SEL_0;
        rsp_adr_d     = '0;
        rsp_slot_d    = '0;
        rsp_full_d    = 1'b0;
        rsp_was_set_d = 1'b0;
        if (op_q == OP_INSERT) begin
          if (found_0) begin
            wr_en = 1'b1; wr_adr = adr0_q;
            wr_word = flag_in_0 | (BUCKET_SIZE'(1) << idx_0);
            rsp_sel_d = SEL_0; rsp_adr_d = adr0_q; rsp_slot_d = idx_0;
          end else if (found_1) begin
            wr_en = 1'b1; wr_adr = adr1_q;
            wr_word = flag_in_1 | (BUCKET_SIZE'(1) << idx_1);
            rsp_sel_d = SEL_1; rsp_adr_d = adr1_q; rsp_slot_d = idx_1;
          end else if (found_2) begin
            wr_en = 1'b1; wr_adr = adr2_q;
            wr_word = flag_in_2 | (BUCKET_SIZE'(1) << idx_2);
            rsp_sel_d = SEL_2; rsp_adr_d = adr2_q; rsp_slot_d = idx_2;
          end else begin
            rsp_full_d = 1'b1;
          end
        end else begin
          rsp_adr_d  = adr0_q;
          rsp_slot_d = slot_q;
          // An out-of-range slot has no flag bit, so nothing is written.
          if (32'(slot_q) < BUCKET_SIZE) begin
            wr_en = 1'b1; wr_adr = adr0_q;
            wr_word = flag_in_0 & ~(BUCKET_SIZE'(1) << slot_q);
            rsp_was_set_d = del_shift[0];
          end
        end
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Write port is combinational and must stay quiet while reset is high.
  assign flag_write_en       = wr_en & ~reset;
  assign flag_write_adr      = reset ? '0 : wr_adr;
  assign flag_write_is_valid = reset ? '0 : wr_word;

  assign req_ready       = (state_q == IDLE);
  assign rsp_valid       = (state_q == RESP);
  assign flag_read_adr_0 = adr0_q;
  assign flag_read_adr_1 = adr1_q;
  assign flag_read_adr_2 = adr2_q;
  assign rsp_sel         = rsp_sel_q;
  assign rsp_adr         = rsp_adr_q;
  assign rsp_slot        = rsp_slot_q;
  assign rsp_full        = rsp_full_q;
  assign rsp_was_set     = rsp_was_set_q;

endmodule

// File: tb/tb_flag_slot_allocator.sv
// Directed bench for flag_slot_allocator with a 1-cycle-latency flag register model.
module tb_flag_slot_allocator;

  localparam int SIZE = 4;
  localparam int BS   = 4;
  localparam int SW   = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic            req_op = 1'b0;
  logic [SIZE-1:0] req_adr_0 = '0, req_adr_1 = '0, req_adr_2 = '0;
  logic [SW-1:0]   req_slot = '0;
  logic [SIZE-1:0] flag_read_adr_0, flag_read_adr_1, flag_read_adr_2;
  logic [BS-1:0]   flag_in_0 = '0, flag_in_1 = '0, flag_in_2 = '0;
  logic [SIZE-1:0] flag_write_adr;
  logic            flag_write_en;
  logic [BS-1:0]   flag_write_is_valid;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [1:0]      rsp_sel;
  logic [SIZE-1:0] rsp_adr;
  logic [SW-1:0]   rsp_slot;
  logic            rsp_full;
  logic            rsp_was_set;

  logic [BS-1:0] mem [16];
  int total = 0;
  int bad = 0;
  int wr_cnt = 0;

  flag_slot_allocator #(.SIZE(SIZE), .BUCKET_SIZE(BS)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_adr_0(req_adr_0), .req_adr_1(req_adr_1), .req_adr_2(req_adr_2),
    .req_slot(req_slot),
    .flag_read_adr_0(flag_read_adr_0), .flag_read_adr_1(flag_read_adr_1),
    .flag_read_adr_2(flag_read_adr_2),
    .flag_in_0(flag_in_0), .flag_in_1(flag_in_1), .flag_in_2(flag_in_2),
    .flag_write_adr(flag_write_adr), .flag_write_en(flag_write_en),
    .flag_write_is_valid(flag_write_is_valid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sel(rsp_sel),
    .rsp_adr(rsp_adr), .rsp_slot(rsp_slot), .rsp_full(rsp_full),
    .rsp_was_set(rsp_was_set)
  );

  always #5 clk = ~clk;

  // Flag register: registered read ports, write lands at the clock edge.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      flag_in_0 <= '0;
      flag_in_1 <= '0;
      flag_in_2 <= '0;
    end else begin
      flag_in_0 <= mem[flag_read_adr_0];
      flag_in_1 <= mem[flag_read_adr_1];
      flag_in_2 <= mem[flag_read_adr_2];
      if (flag_write_en) begin
        mem[flag_write_adr] <= flag_write_is_valid;
        wr_cnt = wr_cnt + 1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic run_req(input logic op, input logic [3:0] a0, input logic [3:0] a1,
                         input logic [3:0] a2, input logic [1:0] slot,
                         input logic exp_we, input logic [3:0] exp_wadr, input logic [3:0] exp_word,
                         input logic [1:0] exp_sel, input logic [3:0] exp_adr,
                         input logic [1:0] exp_slot, input logic exp_full, input logic exp_was,
                         input int hold);
    int wc0;
    @(negedge clk);
    check_eq("idle_req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op;
    req_adr_0 = a0; req_adr_1 = a1; req_adr_2 = a2; req_slot = slot;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    wc0 = wr_cnt;
    check_eq("issue_we", 32'(flag_write_en), 32'd0);
    check_eq("issue_req_ready", 32'(req_ready), 32'd0);
    check_eq("read_adr_0", 32'(flag_read_adr_0), 32'(a0));
    check_eq("read_adr_1", 32'(flag_read_adr_1), op ? 32'(a0) : 32'(a1));
    check_eq("read_adr_2", 32'(flag_read_adr_2), op ? 32'(a0) : 32'(a2));
    @(negedge clk);
    check_eq("check_we", 32'(flag_write_en), 32'(exp_we));
    if (exp_we) begin
      check_eq("check_wadr", 32'(flag_write_adr), 32'(exp_wadr));
      check_eq("check_word", 32'(flag_write_is_valid), 32'(exp_word));
    end
    check_eq("check_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check_eq("rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("rsp_we_off", 32'(flag_write_en), 32'd0);
    check_eq("rsp_wr_count", 32'(wr_cnt - wc0), 32'(exp_we));
    check_eq("rsp_sel", 32'(rsp_sel), 32'(exp_sel));
    check_eq("rsp_adr", 32'(rsp_adr), 32'(exp_adr));
    check_eq("rsp_slot", 32'(rsp_slot), 32'(exp_slot));
    check_eq("rsp_full", 32'(rsp_full), 32'(exp_full));
    check_eq("rsp_was_set", 32'(rsp_was_set), 32'(exp_was));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      check_eq("hold_req_ready", 32'(req_ready), 32'd0);
      check_eq("hold_rsp_adr", 32'(rsp_adr), 32'(exp_adr));
      check_eq("hold_rsp_slot", 32'(rsp_slot), 32'(exp_slot));
      check_eq("hold_rsp_sel", 32'(rsp_sel), 32'(exp_sel));
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq("post_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("post_req_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    int wc;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_we", 32'(flag_write_en), 32'd0);
    check_eq("rst_read_adr", 32'(flag_read_adr_0), 32'd0);
    check_eq("rst_rsp_full", 32'(rsp_full), 32'd0);
    reset = 1'b0;

    // empty table: first slot of adr_0
    run_req(1'b0, 4'd3, 4'd5, 4'd7, 2'd0, 1'b1, 4'd3, 4'b0001, 2'd0, 4'd3, 2'd0, 1'b0, 1'b0, 0);
    // bucket 3 full, bucket 5 first free slot is 2
    mem[3] = 4'b1111; mem[5] = 4'b1011;
    run_req(1'b0, 4'd3, 4'd5, 4'd7, 2'd0, 1'b1, 4'd5, 4'b1111, 2'd1, 4'd5, 2'd2, 1'b0, 1'b0, 0);
    // falls through to adr_2, highest slot
    mem[7] = 4'b0111;
    run_req(1'b0, 4'd3, 4'd5, 4'd7, 2'd0, 1'b1, 4'd7, 4'b1111, 2'd2, 4'd7, 2'd3, 1'b0, 1'b0, 0);
    // all three full
    run_req(1'b0, 4'd3, 4'd5, 4'd7, 2'd0, 1'b0, 4'd0, 4'd0, 2'd0, 4'd0, 2'd0, 1'b1, 1'b0, 0);
    // delete a set bit, then the same bit again
    mem[9] = 4'b0110;
    run_req(1'b1, 4'd9, 4'd1, 4'd2, 2'd2, 1'b1, 4'd9, 4'b0010, 2'd0, 4'd9, 2'd2, 1'b0, 1'b1, 0);
    run_req(1'b1, 4'd9, 4'd1, 4'd2, 2'd2, 1'b1, 4'd9, 4'b0010, 2'd0, 4'd9, 2'd2, 1'b0, 1'b0, 0);
    // back-pressure, then back-to-back inserts into the same bucket
    run_req(1'b0, 4'd2, 4'd2, 4'd2, 2'd0, 1'b1, 4'd2, 4'b0001, 2'd0, 4'd2, 2'd0, 1'b0, 1'b0, 5);
    run_req(1'b0, 4'd2, 4'd2, 4'd2, 2'd0, 1'b1, 4'd2, 4'b0011, 2'd0, 4'd2, 2'd1, 1'b0, 1'b0, 0);

    // reset while in CHECK drops the request
    @(negedge clk);
    req_valid = 1'b1; req_op = 1'b0;
    req_adr_0 = 4'd4; req_adr_1 = 4'd4; req_adr_2 = 4'd4;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    wc = wr_cnt;
    @(negedge clk);
    check_eq("pre_rst_we", 32'(flag_write_en), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_we", 32'(flag_write_en), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_eq("mid_rst_wr_count", 32'(wr_cnt - wc), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_eq("after_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("after_rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("after_rst_read_adr", 32'(flag_read_adr_0), 32'd0);
    check_eq("after_rst_we", 32'(flag_write_en), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flag_slot_allocator.md
Name: flag_slot_allocator

Overview:
- Controller stage directly upstream of the valid-flag register of the hash table.
- Accepts insert/delete requests carrying three precomputed hash addresses.
- Drives the flag register's three read ports, consumes its 1-cycle-latency flag outputs, picks a free bucket slot (insert) or clears a slot (delete), and writes the updated flag word back.
- Returns the chosen location to the key/value datapath over a valid/ready response channel.

Parameters:
- SIZE, 10, address width of the flag register (2**SIZE buckets).
- BUCKET_SIZE, 1, slots per bucket (one flag bit per slot).
- SLOT_W, (BUCKET_SIZE>1 ? $clog2(BUCKET_SIZE) : 1), slot index width (derived localparam).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_op  in  1  0=INSERT, 1=DELETE.
- req_adr_0 / req_adr_1 / req_adr_2  in  SIZE each  hash addresses; DELETE uses req_adr_0 only.
- req_slot  in  SLOT_W  slot to clear (DELETE only).
- flag_read_adr_0 / _1 / _2  out  SIZE each  to flag register read ports.
- flag_in_0 / _1 / _2  in  BUCKET_SIZE each  flag register outputs, valid 1 cycle after address.
- flag_write_adr  out  SIZE  write address.
- flag_write_en  out  1  write strobe.
- flag_write_is_valid  out  BUCKET_SIZE  new flag word for flag_write_adr.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_sel  out  2  which hash address was used (0..2; 0 for DELETE and for full).
- rsp_adr  out  SIZE  bucket address written.
- rsp_slot  out  SLOT_W  slot set or cleared.
- rsp_full  out  1  INSERT found no free slot; no write performed.
- rsp_was_set  out  1  DELETE target slot was set before the clear.

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- FSM states: IDLE, ISSUE, CHECK, RESP.
- IDLE: req_ready=1. On req_valid, capture op, addresses and slot into registers; go to ISSUE. req_ready=0 in all other states.
- flag_read_adr_k are driven continuously from the captured address registers (reset 0). DELETE drives the captured req_adr_0 on all three ports.
- ISSUE: flag register samples the addresses; go to CHECK.
- CHECK: flag_in_k are valid.
  - INSERT: search flag_in_0, then flag_in_1, then flag_in_2; within a word, lowest-index zero bit wins.
    - Free slot found: flag_write_en=1, flag_write_adr = chosen address, flag_write_is_valid = old word | onehot(slot).
    - No free slot: no write, rsp_full=1.
  - DELETE: flag_write_en=1, flag_write_adr=adr_0, flag_write_is_valid = flag_in_0 & ~onehot(slot); rsp_was_set = flag_in_0[slot]. The write is issued even if the bit is already clear.
  - Register all rsp_* fields; go to RESP.
- flag_write_* are asserted only in CHECK, for exactly one cycle. They are combinational from state and flag_in. flag_write_en=0 whenever reset=1.
- RESP: rsp_valid=1; rsp_* held stable until rsp_ready. On handshake go to IDLE. No new request is accepted in this cycle.
- Latency: request accepted in cycle 0, write in cycle 2, rsp_valid from cycle 3. Peak throughput is 1 request per 4 cycles.
- No read-after-write hazard: the write in CHECK lands before the next ISSUE.
- Equal hash addresses are allowed; priority by sel index resolves them.
- Out-of-range req_slot (>= BUCKET_SIZE) on DELETE: no write, rsp_was_set=0.
- Reset values: state IDLE, rsp_valid=0, all rsp_* 0, flag_read_adr_* 0, flag_write_* 0.
- Reset mid-operation: the in-flight request is dropped with no write and no response. The flag register is expected to be reset in the same cycle.

Decomposition:
- Package hash_flag_pkg: op enum (OP_INSERT, OP_DELETE), state enum, sel constants SEL_0..SEL_2.
- Sub-module first_zero_finder: parameterised by BUCKET_SIZE, combinational; outputs found + SLOT_W index of the lowest zero bit. Instantiated three times.

Test Plan:
- SIZE=4, BUCKET_SIZE=4, all flags 0; INSERT adr=(3,5,7) -> write adr 3 word 4'b0001 in cycle 2; rsp sel=0 adr=3 slot=0 full=0.
- adr 3 flags=4'b1111, adr 5=4'b1011; INSERT (3,5,7) -> write adr 5 word 4'b1111; rsp sel=1 slot=2.
- Flags at 3, 5, 7 all 4'b1111; INSERT -> flag_write_en never high; rsp_full=1.
- adr 9=4'b0110; DELETE adr_0=9 slot=2 -> write 4'b0010, rsp_was_set=1. Repeat -> write 4'b0010, rsp_was_set=0.
- rsp_ready held low 5 cycles -> rsp_* stable, req_ready=0. Back-to-back INSERTs to the same adr 2 -> slots 0 then 1.
- Reset asserted in CHECK -> no write that cycle; rsp_valid=0, req_ready=1 the cycle after reset deasserts.
